// File: rtl/led_pkg.sv
// ---------------------------------------------------------------------------
// led_pkg
// Shared definitions for the LED running-light sequencer.
//
// Contents:
//   led_mode_t  - 2-bit sequencing mode, with one named value per mode:
//                 MODE_LEFT  (2'd0) rotate toward the MSB
//                 MODE_RIGHT (2'd1) rotate toward the LSB
//                 MODE_PING  (2'd2) single LED bouncing between the ends
//                 MODE_FILL  (2'd3) bar graph filling from bit 0 upward
//
// Every sequencer state starts from the mode-0 pattern after reset. This is
// why MODE_LEFT is the value that the mode history register resets to.
// ---------------------------------------------------------------------------
package led_pkg;

    typedef enum logic [1:0] {
        MODE_LEFT  = 2'd0,
        MODE_RIGHT = 2'd1,
        MODE_PING  = 2'd2,
        MODE_FILL  = 2'd3
    } led_mode_t;

    // Mode used by the state registers straight out of reset.
    localparam led_mode_t MODE_RESET = MODE_LEFT;

endpackage

// File: rtl/rise_detect.sv
// ---------------------------------------------------------------------------
// rise_detect
// Single-clock rising-edge detector for a level that is already synchronous
// to clk. The pulse is high for the whole cycle in which `in` is high and
// the previous sample was low. The rising clock edge that ends that cycle
// is the one where the consumer should act.
//
// The history flop resets to 1. If the input is already high when reset is
// released, that level is not reported as an edge. The input must go low
// and then high again before a pulse appears. Button inputs rely on the
// same behaviour, so the same module serves them.
//
// Ports:
//   clk    in   1  clock
//   rst    in   1  asynchronous active-high reset
//   in     in   1  synchronous level to watch
//   pulse  out  1  combinational one-cycle rising-edge strobe
// ---------------------------------------------------------------------------
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic pulse
);

    logic prev;

    // History flop. It holds the level from the previous clock. It resets
    // high so that a level already asserted at reset is not seen as an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev <= 1'b1;
        end else begin
            prev <= in;
        end
    end

    // An edge is a high sample whose previous sample was low.
    assign pulse = in & ~prev;

endmodule

// File: rtl/led_chaser.sv
// ---------------------------------------------------------------------------
// led_chaser
// Running-light sequencer driven by the 1 Hz square wave from the divider.
// Each detected rising edge of div_clk advances an N-bit LED pattern in the
// selected mode: rotate left, rotate right, ping-pong or bar fill.
//
// Parameters:
//   N           number of LEDs, 2..16
//   ACTIVE_LOW  1: led_out is the inverse of the internal pattern
//
// Ports:
//   clk_50M  in   1  system clock
//   rst      in   1  asynchronous active-high reset
//   div_clk  in   1  divided square wave, synchronous to clk_50M
//   mode     in   2  0 left, 1 right, 2 ping-pong, 3 fill
//   pause    in   1  while high, detected steps are discarded
//   led_out  out  N  registered LED drive, polarity set by ACTIVE_LOW
//   wrap     out  1  one-cycle pulse aligned with led_out. It marks the
//                    step that completes one full sequence period.
//
// Timing: the internal state updates on the clock edge that first samples
// div_clk high. led_out and wrap show that update one clock later.
// ---------------------------------------------------------------------------
module led_chaser
    import led_pkg::*;
#(
    parameter int N          = 8,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic         clk_50M,
    input  logic         rst,
    input  logic         div_clk,
    input  logic [1:0]   mode,
    input  logic         pause,
    output logic [N-1:0] led_out,
    output logic         wrap
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(N + 1);

    localparam logic [N-1:0]  ONE_HOT_LSB = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0]  ONE_HOT_MSB = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0]  POLARITY    = {N{ACTIVE_LOW}};
    localparam logic [N-1:0]  LED_RESET   = POLARITY ^ ONE_HOT_LSB;
    localparam logic [PW-1:0] POS_MAX     = PW'(N - 1);
    localparam logic [CW-1:0] COUNT_MAX   = CW'(N);

    logic            step;
    logic            advance;
    logic            mode_changed;
    led_mode_t       mode_in;

    led_mode_t       mode_q;
    logic [N-1:0]    pattern;
    logic [PW-1:0]   pos;
    logic            dir_up;
    logic [CW-1:0]   count;
    logic            wrap_q;

    logic [N-1:0]    pattern_next;
    logic [PW-1:0]   pos_next;
    logic            dir_next;
    logic [CW-1:0]   count_next;
    logic            wrap_next;

    // Bar-graph mask for fill mode: the lowest c bits are lit.
    function automatic logic [N-1:0] fill_mask(input logic [CW-1:0] c);
        logic [N-1:0] m;
        m = '0;
        for (int i = 0; i < N; i++) begin
            m[i] = (CW'(i) < c);
        end
        return m;
    endfunction

    rise_detect u_step_detect (
        .clk   (clk_50M),
        .rst   (rst),
        .in    (div_clk),
        .pulse (step)
    );

    // A mode change takes priority over everything else. A step advances
    // the pattern only when pause is low. A step that arrives while paused
    // is dropped and is not kept for later.
    assign mode_in      = led_mode_t'(mode);
    assign mode_changed = (mode_in != mode_q);
    assign advance      = step & ~pause;

    // State register. Reset restores the mode-0 pattern whatever the mode
    // input is. Because mode_q also returns to MODE_LEFT, a nonzero mode
    // input is seen as a change on the first clock after reset is released.
    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            mode_q  <= MODE_RESET;
            pattern <= ONE_HOT_LSB;
            pos     <= '0;
            dir_up  <= 1'b1;
            count   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            mode_q  <= mode_in;
            pattern <= pattern_next;
            pos     <= pos_next;
            dir_up  <= dir_next;
            count   <= count_next;
            wrap_q  <= wrap_next;
        end
    end

    // Next-state logic. A reload starts the new mode from its initial
    // pattern. It also clears the ping-pong and fill bookkeeping, so every
    // mode starts from a known point, and it never raises wrap. A step
    // follows the current mode (mode_q). wrap is raised on the step that
    // brings the sequence back to its starting pattern.
    always_comb begin
        pattern_next = pattern;
        pos_next     = pos;
        dir_next     = dir_up;
        count_next   = count;
        wrap_next    = 1'b0;

        if (mode_changed) begin
            pos_next   = '0;
            dir_next   = 1'b1;
            count_next = '0;
            case (mode_in)
                MODE_LEFT:  pattern_next = ONE_HOT_LSB;
                MODE_RIGHT: pattern_next = ONE_HOT_MSB;
                MODE_PING:  pattern_next = ONE_HOT_LSB;
                MODE_FILL:  pattern_next = '0;
                default:    pattern_next = ONE_HOT_LSB;
            endcase
        end else if (advance) begin
            case (mode_q)
                MODE_LEFT: begin
                    pattern_next = {pattern[N-2:0], pattern[N-1]};
                    wrap_next    = pattern[N-1];
                end
                MODE_RIGHT: begin
                    pattern_next = {pattern[0], pattern[N-1:1]};
                    wrap_next    = pattern[0];
                end
                MODE_PING: begin
                    if (dir_up) begin
                        pos_next = pos + 1'b1;
                        if (pos_next == POS_MAX) begin
                            dir_next = 1'b0;
                        end
                    end else begin
                        pos_next = pos - 1'b1;
                        if (pos_next == '0) begin
                            dir_next  = 1'b1;
                            wrap_next = 1'b1;
                        end
                    end
                    pattern_next = ONE_HOT_LSB << pos_next;
                end
                MODE_FILL: begin
                    if (count == COUNT_MAX) begin
                        count_next = '0;
                        wrap_next  = 1'b1;
                    end else begin
                        count_next = count + 1'b1;
                    end
                    pattern_next = fill_mask(count_next);
                end
                default: begin
                    pattern_next = pattern;
                end
            endcase
        end
    end

    // Output register. It delays the pattern and wrap by one clock so that
    // led_out and wrap change together. It also applies the LED polarity.
    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            led_out <= LED_RESET;
            wrap    <= 1'b0;
        end else begin
            led_out <= pattern ^ POLARITY;
            wrap    <= wrap_q;
        end
    end

endmodule

// File: doc/led_chaser.md
# led_chaser

Running-light sequencer that consumes the 1 Hz square wave produced by the one-second divider stage and drives the board LED bank. Each rising edge of the divided clock advances an N-bit LED pattern according to a selectable mode: rotate left, rotate right, ping-pong or bar fill. It sits between the divider and the LED pins and is the direct consumer of the divider's output.

## Interface
- N, 8, number of LEDs; legal range 2..16.
- ACTIVE_LOW, 1, when 1 `led_out` is the bitwise inverse of the internal pattern (LED lit = 0).
- clk_50M  input  1  system clock, 50 MHz.
- rst  input  1  reset, asynchronous, active-high; single clock domain `clk_50M`.
- div_clk  input  1  divided square wave from the divider stage, synchronous to `clk_50M`.
- mode  input  2  0 = rotate left, 1 = rotate right, 2 = ping-pong, 3 = bar fill.
- pause  input  1  while high, steps are ignored and the pattern holds.
- led_out  output  N  LED drive, registered, polarity per ACTIVE_LOW.
- wrap  output  1  one-cycle pulse aligned with `led_out`, marking completion of one full sequence period.

## Operation
- Step detect: `prev` register holds `div_clk` from the previous cycle. `step = div_clk & ~prev`. `prev` resets to 1, so a high `div_clk` at reset release does not produce a step.
- `mode_q` register holds last cycle's `mode`. A change (`mode != mode_q`) reloads the initial state of the new mode. A mode change overrides a coincident step and `pause`.
- Initial patterns:
  - left: `1` (bit 0).
  - right: bit N-1.
  - ping-pong: bit 0, direction up.
  - fill: all zeros, count 0.
- On a step with `pause` low:
  - left: rotate toward MSB; bit N-1 wraps to bit 0; wrap pulses.
  - right: rotate toward LSB; bit 0 wraps to bit N-1; wrap pulses.
  - ping-pong: position moves up or down by 1. Direction flips when the position reaches N-1 (going up) or 0 (going down). Period is 2N-2 steps. Wrap pulses on the step that arrives at position 0.
  - fill: count increments 0..N; pattern = `(1<<count)-1`. The step from N loads count 0 (all off) and pulses wrap.
- Exactly one LED is lit in modes 0–2 at all times. Fill uses a count register of width `$clog2(N+1)`.
- Reset values: pattern = bit 0, `mode_q` = 0, position = 0, direction = up, count = 0. `led_out` = `{N{ACTIVE_LOW}} ^ 1` (8'hFE for the defaults). `wrap` = 0.
- Reset mid-sequence returns to the reset state immediately, asynchronously. The mode-0 pattern is restored even if `mode != 0`. Because `mode_q` resets to 0, a nonzero `mode` is seen as a change on the first clock after release, which loads that mode's initial pattern.

## Timing
- Edge k is the first `clk_50M` edge at which `div_clk` is sampled high after being low.
- The internal pattern and state update at edge k.
- `led_out` and `wrap` update at edge k+1. Latency from div_clk rise to LED change is 1 cycle after detection.
- `wrap` is high for exactly one cycle per period. It is never asserted on a mode-change reload.
- `pause` is sampled at edge k. A step while paused is lost, not deferred.
- `div_clk` pulses shorter than 1 cycle are not supported; the divider guarantees 25,000,000-cycle half-periods.

## Structure
- Package `led_pkg`: mode constants MODE_LEFT=2'd0, MODE_RIGHT=2'd1, MODE_PING=2'd2, MODE_FILL=2'd3, and a `led_mode_t` 2-bit typedef.
- Sub-module `rise_detect` (clk, rst, in, pulse) with a reset value of 1 on its history flop. It is reused later for button inputs.
- Top level: mode/reload logic, a pattern next-state case on `mode_q`, and the output register.

## Test plan
- Reset with div_clk=1, mode=0 -> led_out=8'hFE, no step until div_clk falls and rises again; then led_out=8'hFD one cycle after detection.
- Mode 0, 8 steps -> patterns 01,02,…,80,01 (pre-inversion); wrap pulses once, on the 80->01 step, aligned with led_out.
- Mode 2, 14 steps -> position 0→7→0; direction flips at 7 and 0; wrap pulses only on the 14th step.
- Mode 3, 9 steps -> 00,01,03,…,FF,00; wrap on the FF->00 step; then change mode to 1 on the same cycle as a step -> pattern 80 loaded, no wrap.
- pause=1 across 3 div_clk rises -> led_out constant; pause=0 -> the next rise advances exactly one position.
- Assert rst mid-fill (pattern 1F) -> led_out=8'hFE asynchronously; after release with mode=3, pattern 00 loaded at the first clock.
